// File: rtl/row_seq_pkg.sv
// Shared definitions for the configuration-array row sequencer: FSM states,
// default geometry and the (group, row) to flat word-line index mapping.
package row_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_COL = 2'd1,
        ST_DRIVE    = 2'd2,
        ST_RECOVER  = 2'd3
    } state_e;

    localparam int unsigned DEF_NUM_GROUPS     = 19;
    localparam int unsigned DEF_ROWS_PER_BLOCK = 9;
    localparam int unsigned DEF_G_ADDR_W       = 6;
    localparam int unsigned DEF_R_ADDR_W       = 4;
    localparam int unsigned DEF_PULSE_W        = 4;

    function automatic int unsigned wl_index(input int unsigned g,
                                             input int unsigned r,
                                             input int unsigned rows_per_block);
        return g * rows_per_block + r;
    endfunction

endpackage

// File: rtl/row_sequencer_if.sv
// Command, column-loader handshake and word-line status bundle of the row sequencer.
interface row_sequencer_if
    import row_seq_pkg::*;
#(
    parameter int unsigned NUM_GROUPS     = DEF_NUM_GROUPS,
    parameter int unsigned ROWS_PER_BLOCK = DEF_ROWS_PER_BLOCK,
    parameter int unsigned G_ADDR_W       = DEF_G_ADDR_W,
    parameter int unsigned R_ADDR_W       = DEF_R_ADDR_W,
    parameter int unsigned PULSE_W        = DEF_PULSE_W
);
    localparam int unsigned NUM_ROWS = NUM_GROUPS * ROWS_PER_BLOCK;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_scan;
    logic [G_ADDR_W-1:0] cmd_g_addr;
    logic [R_ADDR_W-1:0] cmd_r_addr;
    logic [PULSE_W-1:0]  pulse_len;
    logic                abort;
    logic                col_valid;
    logic                col_ack;
    logic [NUM_ROWS-1:0] wl;
    logic                busy;
    logic [G_ADDR_W-1:0] cur_g;
    logic [R_ADDR_W-1:0] cur_r;
    logic                done;
    logic                err;

    modport master (
        output cmd_valid, cmd_scan, cmd_g_addr, cmd_r_addr, pulse_len, abort, col_valid,
        input  cmd_ready, col_ack, wl, busy, cur_g, cur_r, done, err
    );

    modport slave (
        input  cmd_valid, cmd_scan, cmd_g_addr, cmd_r_addr, pulse_len, abort, col_valid,
        output cmd_ready, col_ack, wl, busy, cur_g, cur_r, done, err
    );

endinterface

// File: rtl/row_onehot_decoder.sv
// Combinational (group, row, enable) to one-hot word-line decoder for any
// NUM_GROUPS x ROWS_PER_BLOCK geometry; out-of-range addresses decode to zero.
module row_onehot_decoder
    import row_seq_pkg::*;
#(
    parameter int unsigned NUM_GROUPS     = DEF_NUM_GROUPS,
    parameter int unsigned ROWS_PER_BLOCK = DEF_ROWS_PER_BLOCK,
    parameter int unsigned G_ADDR_W       = DEF_G_ADDR_W,
    parameter int unsigned R_ADDR_W       = DEF_R_ADDR_W
) (
    input  logic [G_ADDR_W-1:0]                  g_i,
    input  logic [R_ADDR_W-1:0]                  r_i,
    input  logic                                 en_i,
    output logic [NUM_GROUPS*ROWS_PER_BLOCK-1:0] onehot_o
);
    localparam int unsigned NUM_ROWS = NUM_GROUPS * ROWS_PER_BLOCK;
    localparam int unsigned IDX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    always_comb begin
        onehot_o = '0;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            for (int unsigned r = 0; r < ROWS_PER_BLOCK; r++) begin
                if (en_i && (g_i == G_ADDR_W'(g)) && (r_i == R_ADDR_W'(r))) begin
                    onehot_o[IDX_W'(wl_index(g, r, ROWS_PER_BLOCK))] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/row_sequencer.sv
// Registered row sequencer: single-row or full-scan word-line pulsing with a
// column-loader handshake, programmable pulse width, recovery gap and abort.
module row_sequencer
    import row_seq_pkg::*;
#(
    parameter int unsigned NUM_GROUPS     = DEF_NUM_GROUPS,
    parameter int unsigned ROWS_PER_BLOCK = DEF_ROWS_PER_BLOCK,
    parameter int unsigned G_ADDR_W       = DEF_G_ADDR_W,
    parameter int unsigned R_ADDR_W       = DEF_R_ADDR_W,
    parameter int unsigned PULSE_W        = DEF_PULSE_W
) (
    input logic           clk,
    input logic           reset_n,
    row_sequencer_if.slave bus
);
    localparam int unsigned         NUM_ROWS = NUM_GROUPS * ROWS_PER_BLOCK;
    localparam logic [G_ADDR_W-1:0] LAST_G   = G_ADDR_W'(NUM_GROUPS - 1);
    localparam logic [R_ADDR_W-1:0] LAST_R   = R_ADDR_W'(ROWS_PER_BLOCK - 1);
    localparam logic [PULSE_W-1:0]  ONE_P    = PULSE_W'(1);

    state_e              state_q, state_d;
    logic [G_ADDR_W-1:0] cur_g_q, cur_g_d;
    logic [R_ADDR_W-1:0] cur_r_q, cur_r_d;
    logic                scan_q, scan_d;
    logic [PULSE_W-1:0]  plen_q, plen_d;
    logic [PULSE_W-1:0]  cnt_q, cnt_d;
    logic [NUM_ROWS-1:0] wl_q, wl_d;
    logic                col_ack_q, col_ack_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                in_range;
    logic [PULSE_W-1:0]  plen_in;

    assign in_range = (32'(bus.cmd_g_addr) < NUM_GROUPS) && (32'(bus.cmd_r_addr) < ROWS_PER_BLOCK);
    // A zero pulse length is promoted to a single cycle at latch time
    assign plen_in  = (bus.pulse_len == '0) ? ONE_P : bus.pulse_len;

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cur_g_d = cur_g_q;
        cur_r_d = cur_r_q;
        scan_d  = scan_q;
        plen_d  = plen_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_scan) begin
                        cur_g_d = '0;
                        cur_r_d = '0;
                        scan_d  = 1'b1;
                        plen_d  = plen_in;
                        state_d = ST_WAIT_COL;
                    end else if (in_range) begin
                        cur_g_d = bus.cmd_g_addr;
                        cur_r_d = bus.cmd_r_addr;
                        scan_d  = 1'b0;
                        plen_d  = plen_in;
                        state_d = ST_WAIT_COL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_COL: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.col_valid) begin
                    cnt_d   = plen_q - ONE_P;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - ONE_P;
                end
            end
            ST_RECOVER: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!scan_q || ((cur_g_q == LAST_G) && (cur_r_q == LAST_R))) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_COL;
                    if (cur_r_q == LAST_R) begin
                        cur_r_d = '0;
                        cur_g_d = cur_g_q + G_ADDR_W'(1);
                    end else begin
                        cur_r_d = cur_r_q + R_ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        col_ack_d = (state_d == ST_RECOVER);
        busy_d    = (state_d != ST_IDLE);
    end

    row_onehot_decoder #(
        .NUM_GROUPS    (NUM_GROUPS),
        .ROWS_PER_BLOCK(ROWS_PER_BLOCK),
        .G_ADDR_W      (G_ADDR_W),
        .R_ADDR_W      (R_ADDR_W)
    ) u_decoder (
        .g_i     (cur_g_q),
        .r_i     (cur_r_q),
        .en_i    (state_d == ST_DRIVE),
        .onehot_o(wl_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_g_q   <= '0;
            cur_r_q   <= '0;
            scan_q    <= 1'b0;
            plen_q    <= ONE_P;
            cnt_q     <= '0;
            wl_q      <= '0;
            col_ack_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_g_q   <= cur_g_d;
            cur_r_q   <= cur_r_d;
            scan_q    <= scan_d;
            plen_q    <= plen_d;
            cnt_q     <= cnt_d;
            wl_q      <= wl_d;
            col_ack_q <= col_ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.col_ack   = col_ack_q;
    assign bus.wl        = wl_q;
    assign bus.busy      = busy_q;
    assign bus.cur_g     = cur_g_q;
    assign bus.cur_r     = cur_r_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_row_sequencer.sv
// Bench for row_sequencer: randomized commands checked against a row-list model
// of the expected word-line trace, handshake counts and completion timing.
module tb_row_sequencer;
    localparam int unsigned NG  = 19;
    localparam int unsigned RPB = 9;
    localparam int unsigned GW  = 6;
    localparam int unsigned RW  = 4;
    localparam int unsigned PW  = 4;
    localparam int unsigned NR  = NG * RPB;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    row_sequencer_if #(.NUM_GROUPS(NG), .ROWS_PER_BLOCK(RPB), .G_ADDR_W(GW),
                       .R_ADDR_W(RW), .PULSE_W(PW)) bus ();

    row_sequencer #(.NUM_GROUPS(NG), .ROWS_PER_BLOCK(RPB), .G_ADDR_W(GW),
                    .R_ADDR_W(RW), .PULSE_W(PW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_cmd
    int wl_trace[$];
    int exp_trace[$];
    int n_ack, n_done, n_err, ack_k, done_k, err_k;
    int pop_viol, ovl_viol, cv_viol;
    bit timed_out;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff();
        if (wl_trace.size() != exp_trace.size())
            return (wl_trace.size() < exp_trace.size()) ? wl_trace.size() : exp_trace.size();
        foreach (wl_trace[i]) if (wl_trace[i] != exp_trace[i]) return i;
        return -1;
    endfunction

    // Model: each row in command order is driven for max(P,1) cycles
    task automatic build_expected(input bit scan, input int g, input int r, input int p);
        int pe;
        pe = (p == 0) ? 1 : p;
        exp_trace.delete();
        for (int row = 0; row < NR; row++) begin
            if (scan || row == g * RPB + r)
                for (int c = 0; c < pe; c++) exp_trace.push_back(row);
        end
    endtask

    // Issue one command and record what the word lines and strobes do until done/err
    task automatic run_cmd(input bit scan, input int g, input int r, input int p,
                           input bit rand_cv, input bit abort_acc, input int budget);
        int k, idx, prev_idx;
        bit cv, prev_nz;
        wl_trace.delete();
        n_ack = 0; n_done = 0; n_err = 0; ack_k = -1; done_k = -1; err_k = -1;
        pop_viol = 0; ovl_viol = 0; cv_viol = 0; timed_out = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_scan   = scan;
        bus.cmd_g_addr = GW'(g);
        bus.cmd_r_addr = RW'(r);
        bus.pulse_len  = PW'(p);
        bus.abort      = abort_acc;
        bus.col_valid  = 1'b0;
        cv = 1'b0;
        step();
        bus.cmd_valid  = 1'b0;
        bus.abort      = 1'b0;
        bus.cmd_scan   = 1'($urandom);
        bus.cmd_g_addr = GW'($urandom);
        bus.cmd_r_addr = RW'($urandom);
        bus.pulse_len  = PW'($urandom);
        prev_nz = 1'b0; prev_idx = -1; k = 1;
        forever begin
            if (bus.wl != '0) begin
                if ($countones(bus.wl) > 1) pop_viol++;
                idx = -1;
                for (int i = 0; i < NR; i++) if (bus.wl[i] && idx < 0) idx = i;
                if (!prev_nz && !cv) cv_viol++;
                if (prev_nz && idx != prev_idx) ovl_viol++;
                wl_trace.push_back(idx);
                prev_nz = 1'b1; prev_idx = idx;
            end else begin
                prev_nz = 1'b0;
            end
            if (bus.col_ack) begin n_ack++; ack_k = k; end
            if (bus.done) begin n_done++; done_k = k; end
            if (bus.err) begin n_err++; err_k = k; end
            if (bus.done || bus.err) break;
            if (k >= budget) begin timed_out = 1'b1; break; end
            cv = rand_cv ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.col_valid = cv;
            step();
            k++;
        end
        bus.col_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR-1:0] exp_wl;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_scan = 1'b0; bus.cmd_g_addr = '0; bus.cmd_r_addr = '0;
        bus.pulse_len = '0; bus.abort = 1'b0; bus.col_valid = 1'b0;
        step(); step();
        checks++; if (bus.wl !== '0) begin errors++; $display("FAIL reset_wl: got %h want 0", bus.wl); end
        checks++; if ({bus.busy, bus.done, bus.err, bus.col_ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: busy/done/err/ack got %b want 0000",
                               {bus.busy, bus.done, bus.err, bus.col_ack}); end
        checks++; if ({bus.cur_g, bus.cur_r} !== '0) begin
            errors++; $display("FAIL reset_cur: got g=%0d r=%0d want 0,0", bus.cur_g, bus.cur_r); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        reset_n = 1'b1;
        step();
        // Reset in the second drive cycle of single (3,4), P=5
        bus.cmd_valid = 1'b1; bus.cmd_scan = 1'b0; bus.cmd_g_addr = GW'(3); bus.cmd_r_addr = RW'(4);
        bus.pulse_len = PW'(5); bus.col_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        exp_wl = '0; exp_wl[3 * RPB + 4] = 1'b1;
        checks++; if (bus.wl !== exp_wl) begin errors++; $display("FAIL drive_before_reset: got %h want %h", bus.wl, exp_wl); end
        step();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.wl !== '0) begin errors++; $display("FAIL async_reset_wl: got %h want 0", bus.wl); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", bus.busy); end
        bus.col_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_ready: ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_single_max();
        int d;
        build_expected(1'b0, NG - 1, RPB - 1, 3);
        run_cmd(1'b0, NG - 1, RPB - 1, 3, 1'b0, 1'b0, 40);
        checks++; if (timed_out) begin errors++; $display("FAIL single_max_timeout: got timeout want done"); end
        d = first_diff();
        checks++; if (d != -1) begin errors++; $display("FAIL single_max_trace: diff at %0d, got %0d entries want %0d", d, wl_trace.size(), exp_trace.size()); end
        checks++; if (n_ack != 1 || ack_k != 5) begin errors++; $display("FAIL single_max_ack: got count=%0d at=%0d want 1 at 5", n_ack, ack_k); end
        checks++; if (n_done != 1 || done_k != 6) begin errors++; $display("FAIL single_max_done: got count=%0d at=%0d want 1 at 6", n_done, done_k); end
        checks++; if (bus.cur_g !== GW'(NG - 1) || bus.cur_r !== RW'(RPB - 1)) begin
            errors++; $display("FAIL single_max_cur: got %0d,%0d want %0d,%0d", bus.cur_g, bus.cur_r, NG - 1, RPB - 1); end
    endtask

    task automatic test_out_of_range();
        int gs[4];
        int rs[4];
        gs[0] = NG; rs[0] = 0;
        gs[1] = 0;  rs[1] = RPB;
        gs[2] = $urandom_range(NG, (1 << GW) - 1); rs[2] = $urandom_range(0, RPB - 1);
        gs[3] = $urandom_range(0, NG - 1); rs[3] = $urandom_range(RPB, (1 << RW) - 1);
        for (int i = 0; i < 4; i++) begin
            run_cmd(1'b0, gs[i], rs[i], 2, 1'b0, 1'b0, 10);
            checks++; if (n_err != 1 || err_k != 1) begin
                errors++; $display("FAIL oor_err g=%0d r=%0d: got count=%0d at=%0d want 1 at 1", gs[i], rs[i], n_err, err_k); end
            checks++; if (wl_trace.size() != 0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL oor_idle g=%0d r=%0d: wl_cycles=%0d busy=%b ready=%b want 0/0/1",
                                   gs[i], rs[i], wl_trace.size(), bus.busy, bus.cmd_ready); end
        end
    endtask

    task automatic test_random_single();
        int g, r, p, d;
        for (int i = 0; i < 6; i++) begin
            g = $urandom_range(0, NG - 1); r = $urandom_range(0, RPB - 1); p = $urandom_range(0, 15);
            build_expected(1'b0, g, r, p);
            run_cmd(1'b0, g, r, p, 1'b1, 1'b0, 200);
            d = first_diff();
            checks++; if (timed_out || d != -1) begin
                errors++; $display("FAIL rand_single_trace g=%0d r=%0d p=%0d: timeout=%0b diff=%0d got %0d want %0d",
                                   g, r, p, timed_out, d, wl_trace.size(), exp_trace.size()); end
            checks++; if (n_ack != 1 || n_done != 1 || cv_viol != 0) begin
                errors++; $display("FAIL rand_single_hs p=%0d: acks=%0d dones=%0d early_wl=%0d want 1/1/0", p, n_ack, n_done, cv_viol); end
            checks++; if (bus.cur_g !== GW'(g) || bus.cur_r !== RW'(r)) begin
                errors++; $display("FAIL rand_single_cur: got %0d,%0d want %0d,%0d", bus.cur_g, bus.cur_r, g, r); end
        end
    endtask

    task automatic test_scan_full();
        int d;
        build_expected(1'b1, 0, 0, 0);
        run_cmd(1'b1, 0, 0, 0, 1'b0, 1'b0, 2000);
        d = first_diff();
        checks++; if (timed_out || d != -1) begin
            errors++; $display("FAIL scan_full_trace: timeout=%0b diff=%0d got %0d want %0d", timed_out, d, wl_trace.size(), exp_trace.size()); end
        checks++; if (n_ack != NR) begin errors++; $display("FAIL scan_full_acks: got %0d want %0d", n_ack, NR); end
        checks++; if (n_done != 1 || done_k != 1 + NR * 3) begin
            errors++; $display("FAIL scan_full_done: got count=%0d at=%0d want 1 at %0d", n_done, done_k, 1 + NR * 3); end
        checks++; if (pop_viol != 0 || ovl_viol != 0) begin
            errors++; $display("FAIL scan_full_onehot: multi=%0d overlap=%0d want 0/0", pop_viol, ovl_viol); end
    endtask

    task automatic test_scan_random();
        int p, d, last8, first9;
        p = $urandom_range(0, 2);
        build_expected(1'b1, 0, 0, p);
        run_cmd(1'b1, 0, 0, p, 1'b1, 1'b0, 5000);
        d = first_diff();
        checks++; if (timed_out || d != -1) begin
            errors++; $display("FAIL scan_rand_trace p=%0d: timeout=%0b diff=%0d got %0d want %0d", p, timed_out, d, wl_trace.size(), exp_trace.size()); end
        checks++; if (n_ack != NR || n_done != 1) begin
            errors++; $display("FAIL scan_rand_hs: acks=%0d dones=%0d want %0d/1", n_ack, n_done, NR); end
        checks++; if (cv_viol != 0 || pop_viol != 0 || ovl_viol != 0) begin
            errors++; $display("FAIL scan_rand_rules: early_wl=%0d multi=%0d overlap=%0d want 0/0/0", cv_viol, pop_viol, ovl_viol); end
        last8 = -1; first9 = -1;
        foreach (wl_trace[i]) begin
            if (wl_trace[i] == 8) last8 = i;
            if (wl_trace[i] == 9 && first9 < 0) first9 = i;
        end
        checks++; if (last8 < 0 || first9 != last8 + 1) begin
            errors++; $display("FAIL scan_rand_wrap: last wl8 at %0d, first wl9 at %0d, want adjacent", last8, first9); end
    endtask

    task automatic test_abort();
        int k, stray, d;
        bus.cmd_valid = 1'b1; bus.cmd_scan = 1'b1; bus.pulse_len = PW'(1); bus.col_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!(bus.busy && bus.cur_g == GW'(2) && bus.cur_r == RW'(5) && bus.wl == '0 && !bus.col_ack) && k < 400) begin
            step();
            k++;
        end
        checks++; if (k >= 400) begin errors++; $display("FAIL abort_reach: got timeout want WAIT_COL of (2,5)"); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wl !== '0) begin
            errors++; $display("FAIL abort_idle: busy=%b ready=%b wl_nz=%b want 0/1/0", bus.busy, bus.cmd_ready, bus.wl != '0); end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done || bus.col_ack || bus.wl != '0) stray++;
            step();
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", stray); end
        // Abort coinciding with the accept edge in IDLE must not block the command
        build_expected(1'b0, 0, 0, 2);
        run_cmd(1'b0, 0, 0, 2, 1'b0, 1'b1, 40);
        d = first_diff();
        checks++; if (timed_out || d != -1) begin
            errors++; $display("FAIL after_abort_trace: timeout=%0b diff=%0d got %0d want %0d", timed_out, d, wl_trace.size(), exp_trace.size()); end
        checks++; if (n_ack != 1 || n_done != 1 || done_k != 5) begin
            errors++; $display("FAIL after_abort_done: acks=%0d dones=%0d at=%0d want 1/1 at 5", n_ack, n_done, done_k); end
    endtask

    initial begin
        test_reset();
        test_single_max();
        test_out_of_range();
        test_random_single();
        test_scan_full();
        test_scan_random();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
